// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and its datapath.
// illegalOp is present only when ILLEGAL_OP_TRAP_EN is defined.
interface multicycle_controller_if;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       zero;
   logic       pcWrite;
   logic       adrSrc;
   logic       memWrite;
   logic       irWrite;
   logic [1:0] resultSrc;
   logic [1:0] aluSrcA;
   logic [1:0] aluSrcB;
   logic [1:0] immSrc;
   logic       regWrite;
   logic [2:0] aluControl;
   logic [3:0] state;
`ifdef ILLEGAL_OP_TRAP_EN
   logic       illegalOp;
`endif

   // master: the controller; slave: the datapath side
   modport master (
      input  op, funct3, funct7b5, zero,
      output pcWrite, adrSrc, memWrite, irWrite, resultSrc, aluSrcA, aluSrcB,
             immSrc, regWrite, aluControl, state
`ifdef ILLEGAL_OP_TRAP_EN
      , output illegalOp
`endif
   );

   modport slave (
      output op, funct3, funct7b5, zero,
      input  pcWrite, adrSrc, memWrite, irWrite, resultSrc, aluSrcA, aluSrcB,
             immSrc, regWrite, aluControl, state
`ifdef ILLEGAL_OP_TRAP_EN
      , input illegalOp
`endif
   );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V controller FSM: lw/sw/R/I/beq/jal sequencing and ALU decode.
// Define ILLEGAL_OP_TRAP_EN to trap unlisted opcodes in a TRAP state (illegalOp=1).
module multicycle_controller (
   input logic                     clk,
   input logic                     reset,
   multicycle_controller_if.master bus
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECUTER = 4'd6,
      EXECUTEI = 4'd7,
      ALUWB    = 4'd8,
      BEQ      = 4'd9,
      JAL      = 4'd10
`ifdef ILLEGAL_OP_TRAP_EN
      , TRAP   = 4'd15
`endif
   } state_t;

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

   state_t     cur, nxt;
   logic       pc_update;
   logic       branch;
   logic [1:0] alu_op;

   always_ff @(posedge clk) begin
      if (reset) cur <= FETCH;
      else       cur <= nxt;
   end

   always_comb begin
      nxt = FETCH;
      case (cur)
         FETCH:    nxt = DECODE;
         DECODE: begin
            case (bus.op)
               OP_LW, OP_SW: nxt = MEMADR;
               OP_R:         nxt = EXECUTER;
               OP_I:         nxt = EXECUTEI;
               OP_BEQ:       nxt = BEQ;
               OP_JAL:       nxt = JAL;
`ifdef ILLEGAL_OP_TRAP_EN
               default:      nxt = TRAP;
`else
               default:      nxt = FETCH;
`endif
            endcase
         end
         MEMADR:   nxt = (bus.op == OP_LW) ? MEMREAD : MEMWRITE;
         MEMREAD:  nxt = MEMWB;
         EXECUTER: nxt = ALUWB;
         EXECUTEI: nxt = ALUWB;
         JAL:      nxt = ALUWB;
`ifdef ILLEGAL_OP_TRAP_EN
         TRAP:     nxt = TRAP;
`endif
         default:  nxt = FETCH;
      endcase
   end

   always_comb begin
      pc_update     = 1'b0;
      branch        = 1'b0;
      alu_op        = 2'b00;
      bus.adrSrc    = 1'b0;
      bus.memWrite  = 1'b0;
      bus.irWrite   = 1'b0;
      bus.resultSrc = 2'b00;
      bus.aluSrcA   = 2'b00;
      bus.aluSrcB   = 2'b00;
      bus.regWrite  = 1'b0;
`ifdef ILLEGAL_OP_TRAP_EN
      bus.illegalOp = 1'b0;
`endif
      case (cur)
         FETCH: begin
            bus.irWrite   = 1'b1;
            bus.aluSrcB   = 2'b10;
            bus.resultSrc = 2'b10;
            pc_update     = 1'b1;
         end
         DECODE: begin
            bus.aluSrcA = 2'b01;
            bus.aluSrcB = 2'b01;
         end
         MEMADR: begin
            bus.aluSrcA = 2'b10;
            bus.aluSrcB = 2'b01;
         end
         MEMREAD:  bus.adrSrc = 1'b1;
         MEMWB: begin
            bus.resultSrc = 2'b01;
            bus.regWrite  = 1'b1;
         end
         MEMWRITE: begin
            bus.adrSrc   = 1'b1;
            bus.memWrite = 1'b1;
         end
         EXECUTER: begin
            bus.aluSrcA = 2'b10;
            alu_op      = 2'b10;
         end
         EXECUTEI: begin
            bus.aluSrcA = 2'b10;
            bus.aluSrcB = 2'b01;
            alu_op      = 2'b10;
         end
         ALUWB:    bus.regWrite = 1'b1;
         BEQ: begin
            bus.aluSrcA = 2'b10;
            alu_op      = 2'b01;
            branch      = 1'b1;
         end
         JAL: begin
            bus.aluSrcA = 2'b01;
            bus.aluSrcB = 2'b10;
            pc_update   = 1'b1;
         end
`ifdef ILLEGAL_OP_TRAP_EN
         TRAP:     bus.illegalOp = 1'b1;
`endif
         default: ;
      endcase
   end

   assign bus.pcWrite = pc_update | (branch & bus.zero);
   assign bus.state   = cur;

   always_comb begin
      case (bus.op)
         OP_SW:   bus.immSrc = 2'b01;
         OP_BEQ:  bus.immSrc = 2'b10;
         OP_JAL:  bus.immSrc = 2'b11;
         default: bus.immSrc = 2'b00;
      endcase
   end

   // funct3=000 subtracts only for R-type (op[5]) with bit 30 set
   always_comb begin
      bus.aluControl = 3'b000;
      case (alu_op)
         2'b01: bus.aluControl = 3'b001;
         2'b10: begin
            case (bus.funct3)
               3'b000:  bus.aluControl = (bus.op[5] & bus.funct7b5) ? 3'b001 : 3'b000;
               3'b010:  bus.aluControl = 3'b101;
               3'b110:  bus.aluControl = 3'b011;
               3'b111:  bus.aluControl = 3'b010;
               default: bus.aluControl = 3'b000;
            endcase
         end
         default: bus.aluControl = 3'b000;
      endcase
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller: per-instruction state sequences and
// per-state control values come from a table-driven reference model.
module tb_multicycle_controller;

   logic clk = 1'b0;
   logic reset;
   int   n_tests = 0;
   int   n_fail  = 0;

   multicycle_controller_if bus ();

   multicycle_controller dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   logic [15:0] obs;
   assign obs = {bus.pcWrite, bus.adrSrc, bus.memWrite, bus.irWrite, bus.resultSrc,
                 bus.aluSrcA, bus.aluSrcB, bus.immSrc, bus.regWrite, bus.aluControl};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Expected control vector for a state number, straight from the per-state table.
   function automatic logic [15:0] exp_ctrl(input int st, input logic [6:0] o,
                                            input logic [2:0] f3, input logic f7, input logic z);
      logic       pcu = 0, br = 0, adr = 0, mw = 0, irw = 0, rw = 0, pcw;
      logic [1:0] rs = 0, sa = 0, sb = 0, aop = 0, imm;
      logic [2:0] actl;
      case (st)
         0:  begin irw = 1; sb = 2; rs = 2; pcu = 1; end
         1:  begin sa = 1; sb = 1; end
         2:  begin sa = 2; sb = 1; end
         3:  adr = 1;
         4:  begin rs = 1; rw = 1; end
         5:  begin adr = 1; mw = 1; end
         6:  begin sa = 2; aop = 2; end
         7:  begin sa = 2; sb = 1; aop = 2; end
         8:  rw = 1;
         9:  begin sa = 2; aop = 1; br = 1; end
         10: begin sa = 1; sb = 2; pcu = 1; end
         default: ;
      endcase
      imm = (o == 7'b0100011) ? 2'd1 : (o == 7'b1100011) ? 2'd2 :
            (o == 7'b1101111) ? 2'd3 : 2'd0;
      if (aop == 1) actl = 3'd1;
      else if (aop == 2) begin
         if (f3 == 3'd0)      actl = (o[5] && f7) ? 3'd1 : 3'd0;
         else if (f3 == 3'd2) actl = 3'd5;
         else if (f3 == 3'd6) actl = 3'd3;
         else if (f3 == 3'd7) actl = 3'd2;
         else                 actl = 3'd0;
      end else actl = 3'd0;
      pcw = pcu | (br & z);
      return {pcw, adr, mw, irw, rs, sa, sb, imm, rw, actl};
   endfunction

   // Runs one instruction from FETCH; rst_at is the sequence index where reset is asserted
   // (-1 for none); scramble randomizes op in states where it must not matter.
   task automatic run_instr(input logic [6:0] iop, input int rst_at, input bit scramble);
      int         seq[$];
      int         rpos = rst_at;
      logic [6:0] cur_op;
      case (iop)
         7'b0000011: seq = {0, 1, 2, 3, 4};
         7'b0100011: seq = {0, 1, 2, 5};
         7'b0110011: seq = {0, 1, 6, 8};
         7'b0010011: seq = {0, 1, 7, 8};
         7'b1100011: seq = {0, 1, 9};
         7'b1101111: seq = {0, 1, 10, 8};
         default: begin
`ifdef ILLEGAL_OP_TRAP_EN
            seq  = {0, 1, 15, 15, 15};
            rpos = 4;
`else
            seq = {0, 1};
`endif
         end
      endcase
      for (int i = 0; i < seq.size(); i++) begin
         @(negedge clk);
         cur_op = (seq[i] == 1 || seq[i] == 2 || !scramble) ? iop : 7'($urandom);
         bus.op       = cur_op;
         bus.funct3   = 3'($urandom);
         bus.funct7b5 = 1'($urandom);
         bus.zero     = 1'($urandom);
         reset        = (i == rpos);
         #1;
         check("state", 32'(bus.state), 32'(seq[i]));
         check("ctrl", 32'(obs), 32'(exp_ctrl(seq[i], cur_op, bus.funct3, bus.funct7b5, bus.zero)));
`ifdef ILLEGAL_OP_TRAP_EN
         check("illegalOp", 32'(bus.illegalOp), 32'(seq[i] == 15));
`endif
         if (i == rpos) break;
      end
   endtask

   function automatic logic [6:0] pick_op();
      logic [6:0] ops[9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                             7'b1101111, 7'b1111111, 7'b0010111, 7'b0000000};
      return ops[$urandom_range(0, 8)];
   endfunction

   initial begin
      reset        = 1'b1;
      bus.op       = '0;
      bus.funct3   = '0;
      bus.funct7b5 = 1'b0;
      bus.zero     = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_state", 32'(bus.state), 32'd0);
      check("rst_irWrite", 32'(bus.irWrite), 32'd1);
      check("rst_pcWrite", 32'(bus.pcWrite), 32'd1);
      check("rst_regWrite", 32'(bus.regWrite), 32'd0);
      check("rst_memWrite", 32'(bus.memWrite), 32'd0);

      run_instr(7'b0000011, -1, 1'b0);
      run_instr(7'b0100011, 3, 1'b0);
      run_instr(7'b0110011, -1, 1'b0);
      run_instr(7'b0010011, -1, 1'b0);
      run_instr(7'b1100011, -1, 1'b0);
      run_instr(7'b1101111, -1, 1'b1);
      run_instr(7'b1111111, -1, 1'b0);
      run_instr(7'b0110011, 2, 1'b1);

      for (int n = 0; n < 400; n++) begin
         int ra;
         ra = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 4)) : -1;
         run_instr(pick_op(), ra, 1'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
